// File: rtl/dram_pkg.sv
// -----------------------------------------------------------------------------
// dram_pkg
// Shared definitions for the DRAM bank responder:
//   - command encodings on the 2-bit cmd bus (CMD_ACT/CMD_ACCESS/CMD_REF/CMD_PRE)
//   - per-bank and global state typedefs
//   - default geometry and timing constants
//   - cnt_width(): width of a down-counter that holds 0 .. max_val-1
// -----------------------------------------------------------------------------
package dram_pkg;

   localparam int DEF_NUMBER_OF_BANKS = 8;
   localparam int DEF_NUMBER_OF_ROWS  = 128;
   localparam int DEF_NUMBER_OF_COLS  = 8;
   localparam int DEF_DATA_W          = 16;
   localparam int DEF_T_RCD           = 2;
   localparam int DEF_T_RP            = 2;
   localparam int DEF_T_RFC           = 8;
   localparam int DEF_CL              = 2;

   typedef enum logic [1:0] {
      CMD_ACT    = 2'b00,
      CMD_ACCESS = 2'b01,
      CMD_REF    = 2'b10,
      CMD_PRE    = 2'b11
   } dram_cmd_e;

   typedef enum logic [1:0] {
      BANK_IDLE        = 2'd0,
      BANK_ACTIVATING  = 2'd1,
      BANK_ACTIVE      = 2'd2,
      BANK_PRECHARGING = 2'd3
   } bank_state_e;

   typedef enum logic {
      GLB_NORMAL     = 1'b0,
      GLB_REFRESHING = 1'b1
   } glb_state_e;

   // Counters are loaded with T-1 and count down to 0, so they never hold
   // max_val itself; a single bit is still needed when max_val is 1.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val);
   endfunction

endpackage

// File: rtl/dram_bank_timer.sv
// -----------------------------------------------------------------------------
// dram_bank_timer
// Per-bank state machine: IDLE -> ACTIVATING -> ACTIVE -> PRECHARGING -> IDLE.
// Holds the open row and the tRCD / tRP down-counter for one bank.
//
// A bank whose counter has reached 0 is treated as already in its next state
// for legality: ACTIVATING with count 0 accepts ACCESS/PRECHARGE, and
// PRECHARGING with count 0 accepts ACTIVATE. This makes ACCESS legal exactly
// T_RCD edges after ACTIVATE and ACTIVATE legal exactly T_RP edges after
// PRECHARGE, while bank_open only reflects the registered ACTIVE state.
//
// Ports:
//   clk, rst_b   clock, asynchronous active-low reset
//   act_go       accepted legal ACTIVATE for this bank (latches row_in)
//   pre_go       accepted PRECHARGE of an open bank
//   row_in       row to open
//   open_row     currently latched row
//   bank_open    bank is in ACTIVE state
//   idle_ok      bank may accept ACTIVATE (and counts as idle for REFRESH)
//   active_ok    bank may accept ACCESS / closing PRECHARGE
// -----------------------------------------------------------------------------
module dram_bank_timer
   import dram_pkg::*;
#(
   parameter int ROW_W = $clog2(DEF_NUMBER_OF_ROWS),
   parameter int T_RCD = DEF_T_RCD,
   parameter int T_RP  = DEF_T_RP
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             act_go,
   input  logic             pre_go,
   input  logic [ROW_W-1:0] row_in,
   output logic [ROW_W-1:0] open_row,
   output logic             bank_open,
   output logic             idle_ok,
   output logic             active_ok
);

   localparam int CNT_W = cnt_width((T_RCD > T_RP) ? T_RCD : T_RP);
   localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);

   bank_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ROW_W-1:0] row_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= BANK_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (act_go) begin
            row_q <= row_in;
         end
      end
   end

   // NOTE: every output of this block is defaulted first, so no path through
   // the case statement can leave a value held (which would infer a latch).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         BANK_IDLE: begin
            if (act_go) begin
               state_d = BANK_ACTIVATING;
               cnt_d   = RCD_LOAD;
            end
         end
         BANK_ACTIVATING: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (pre_go) begin
               state_d = BANK_PRECHARGING;
               cnt_d   = RP_LOAD;
            end else begin
               state_d = BANK_ACTIVE;
            end
         end
         BANK_ACTIVE: begin
            if (pre_go) begin
               state_d = BANK_PRECHARGING;
               cnt_d   = RP_LOAD;
            end
         end
         BANK_PRECHARGING: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (act_go) begin
               state_d = BANK_ACTIVATING;
               cnt_d   = RCD_LOAD;
            end else begin
               state_d = BANK_IDLE;
            end
         end
         default: begin
            state_d = BANK_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign open_row  = row_q;
   assign bank_open = (state_q == BANK_ACTIVE);
   assign idle_ok   = (state_q == BANK_IDLE) ||
                      ((state_q == BANK_PRECHARGING) && (cnt_q == '0));
   assign active_ok = (state_q == BANK_ACTIVE) ||
                      ((state_q == BANK_ACTIVATING) && (cnt_q == '0));

endmodule

// File: rtl/dram_bank_responder.sv
// -----------------------------------------------------------------------------
// dram_bank_responder
// Device-side DRAM responder: accepts ACTIVATE / ACCESS / REFRESH / PRECHARGE,
// tracks per-bank open rows (one dram_bank_timer per bank), stores data in a
// {bank, row, col} addressed array and returns read data CL cycles after the
// READ is accepted. Illegal commands change no state and no array contents.
//
// Optional feature: define DRAM_RESP_PROTO_CHECK_EN to report illegal
// commands on err (one-cycle pulse) and err_count (saturating at 255).
// Without it err and err_count are tied to 0 and illegal commands are
// dropped silently.
//
// Ports:
//   clk, rst_b   clock, asynchronous active-low reset
//   cmd_val      command valid
//   cmd_rdy      responder can accept (low only while refreshing)
//   cmd          00 ACTIVATE, 01 ACCESS, 10 REFRESH, 11 PRECHARGE
//   wr_en        with ACCESS: 1 write, 0 read
//   bank_id      target bank
//   row_id       row for ACTIVATE
//   col_id       column for ACCESS
//   wr_data      write data
//   rd_data      read data, valid with rd_valid
//   rd_valid     one-cycle pulse per read
//   bank_open    per-bank ACTIVE flag
//   err          one-cycle pulse after an illegal accept
//   err_count    saturating illegal-command count
// -----------------------------------------------------------------------------
module dram_bank_responder
   import dram_pkg::*;
#(
   parameter int NUMBER_OF_BANKS = DEF_NUMBER_OF_BANKS,
   parameter int NUMBER_OF_ROWS  = DEF_NUMBER_OF_ROWS,
   parameter int NUMBER_OF_COLS  = DEF_NUMBER_OF_COLS,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int T_RCD           = DEF_T_RCD,
   parameter int T_RP            = DEF_T_RP,
   parameter int T_RFC           = DEF_T_RFC,
   parameter int CL              = DEF_CL
) (
   input  logic                               clk,
   input  logic                               rst_b,
   input  logic                               cmd_val,
   output logic                               cmd_rdy,
   input  logic [1:0]                         cmd,
   input  logic                               wr_en,
   input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
   input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
   input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
   input  logic [DATA_W-1:0]                  wr_data,
   output logic [DATA_W-1:0]                  rd_data,
   output logic                               rd_valid,
   output logic [NUMBER_OF_BANKS-1:0]         bank_open,
   output logic                               err,
   output logic [7:0]                         err_count
);

   localparam int BANK_W = $clog2(NUMBER_OF_BANKS);
   localparam int ROW_W  = $clog2(NUMBER_OF_ROWS);
   localparam int COL_W  = $clog2(NUMBER_OF_COLS);
   localparam int ADDR_W = BANK_W + ROW_W + COL_W;
   localparam int RFC_W  = cnt_width(T_RFC);
   localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(T_RFC - 1);

   // ---------------------------------------------------------------- banks
   logic [NUMBER_OF_BANKS-1:0]            act_go;
   logic [NUMBER_OF_BANKS-1:0]            pre_go;
   logic [NUMBER_OF_BANKS-1:0]            idle_ok;
   logic [NUMBER_OF_BANKS-1:0]            active_ok;
   logic [NUMBER_OF_BANKS-1:0][ROW_W-1:0] open_row;

   for (genvar b = 0; b < NUMBER_OF_BANKS; b++) begin : g_bank
      dram_bank_timer #(
         .ROW_W (ROW_W),
         .T_RCD (T_RCD),
         .T_RP  (T_RP)
      ) u_timer (
         .clk       (clk),
         .rst_b     (rst_b),
         .act_go    (act_go[b]),
         .pre_go    (pre_go[b]),
         .row_in    (row_id),
         .open_row  (open_row[b]),
         .bank_open (bank_open[b]),
         .idle_ok   (idle_ok[b]),
         .active_ok (active_ok[b])
      );
   end

   // --------------------------------------------------------------- decode
   dram_cmd_e cmd_e;
   logic      accept;
   logic      wr_go;
   logic      rd_go;
   logic      ref_go;
   logic      illegal;

   assign cmd_e  = dram_cmd_e'(cmd);
   assign accept = cmd_val && cmd_rdy;

   always_comb begin
      act_go  = '0;
      pre_go  = '0;
      wr_go   = 1'b0;
      rd_go   = 1'b0;
      ref_go  = 1'b0;
      illegal = 1'b0;
      if (accept) begin
         case (cmd_e)
            CMD_ACT: begin
               if (idle_ok[bank_id]) act_go[bank_id] = 1'b1;
               else                  illegal         = 1'b1;
            end
            CMD_ACCESS: begin
               if (!active_ok[bank_id]) illegal = 1'b1;
               else if (wr_en)          wr_go   = 1'b1;
               else                     rd_go   = 1'b1;
            end
            CMD_REF: begin
               if (&idle_ok) ref_go  = 1'b1;
               else          illegal = 1'b1;
            end
            CMD_PRE: begin
               // Precharging an idle bank is a legal no-op.
               if (active_ok[bank_id])    pre_go[bank_id] = 1'b1;
               else if (!idle_ok[bank_id]) illegal        = 1'b1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- array
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rd_word;

   assign mem_addr = {bank_id, open_row[bank_id], col_id};

   // NOTE: the storage array deliberately has no reset; its contents are
   // undefined after reset and clearing it would need one write per word.
   always_ff @(posedge clk) begin
      if (wr_go) begin
         mem[mem_addr] <= wr_data;
      end
      if (rd_go) begin
         rd_word <= mem[mem_addr];
      end
   end

   // -------------------------------------------------------- read pipeline
   // Stage 0 is the array read register; stages 1..CL carry valid/data so
   // rd_valid appears after edge k+CL. Reset drops reads in flight.
   logic [CL:0]             rd_pipe_v;
   logic [CL:1][DATA_W-1:0] rd_pipe_d;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rd_pipe_v <= '0;
         rd_pipe_d <= '0;
      end else begin
         rd_pipe_v    <= {rd_pipe_v[CL-1:0], rd_go};
         rd_pipe_d[1] <= rd_pipe_v[0] ? rd_word : '0;
         for (int i = 2; i <= CL; i++) begin
            rd_pipe_d[i] <= rd_pipe_d[i-1];
         end
      end
   end

   assign rd_valid = rd_pipe_v[CL];
   assign rd_data  = rd_pipe_d[CL];

   // -------------------------------------------------------------- refresh
   glb_state_e       glb_q, glb_d;
   logic [RFC_W-1:0] rfc_q, rfc_d;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         glb_q <= GLB_NORMAL;
         rfc_q <= '0;
      end else begin
         glb_q <= glb_d;
         rfc_q <= rfc_d;
      end
   end

   always_comb begin
      glb_d = glb_q;
      rfc_d = rfc_q;
      case (glb_q)
         GLB_NORMAL: begin
            if (ref_go) begin
               glb_d = GLB_REFRESHING;
               rfc_d = RFC_LOAD;
            end
         end
         GLB_REFRESHING: begin
            if (rfc_q != '0) rfc_d = rfc_q - 1'b1;
            else             glb_d = GLB_NORMAL;
         end
         default: begin
            glb_d = GLB_NORMAL;
            rfc_d = '0;
         end
      endcase
   end

   assign cmd_rdy = (glb_q == GLB_NORMAL);

   // ------------------------------------------------------ error reporting
`ifdef DRAM_RESP_PROTO_CHECK_EN
   logic       err_q;
   logic [7:0] err_count_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         err_q       <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         err_q <= illegal;
         if (illegal && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   assign err       = err_q;
   assign err_count = err_count_q;
`else
   // Illegal commands are still decoded (and dropped); nothing reports them.
   logic illegal_unused;
   assign illegal_unused = illegal;
   assign err            = 1'b0;
   assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_dram_bank_responder.sv
// -----------------------------------------------------------------------------
// tb_dram_bank_responder
// Directed stimulus with hand-computed expectations. Each accepted READ pushes
// {expected data, expected rd_valid cycle} into a queue and each illegal
// command (when DRAM_RESP_PROTO_CHECK_EN is defined) pushes its expected err
// cycle; a monitor on the falling edge pops and compares whenever the DUT
// presents rd_valid / err.
// -----------------------------------------------------------------------------
module tb_dram_bank_responder;
   import dram_pkg::*;

   localparam int CL = 2;

`ifdef DRAM_RESP_PROTO_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_b;
   logic        cmd_val;
   logic        cmd_rdy;
   logic [1:0]  cmd;
   logic        wr_en;
   logic [2:0]  bank_id;
   logic [6:0]  row_id;
   logic [2:0]  col_id;
   logic [15:0] wr_data;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [7:0]  bank_open;
   logic        err;
   logic [7:0]  err_count;

   dram_bank_responder dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .cmd_val   (cmd_val),
      .cmd_rdy   (cmd_rdy),
      .cmd       (cmd),
      .wr_en     (wr_en),
      .bank_id   (bank_id),
      .row_id    (row_id),
      .col_id    (col_id),
      .wr_data   (wr_data),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .bank_open (bank_open),
      .err       (err),
      .err_count (err_count)
   );

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   int      err_q[$];
   int      checks      = 0;
   int      failures    = 0;
   int      cyc         = 0;
   int      exp_err_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one command for the next rising edge; k is that edge's number.
   task automatic drive(input logic [1:0] c, input logic w, input int b, input int r,
                        input int col, input logic [15:0] d, input bit ill, output int k);
      @(negedge clk);
      cmd_val = 1'b1;
      cmd     = c;
      wr_en   = w;
      bank_id = 3'(b);
      row_id  = 7'(r);
      col_id  = 3'(col);
      wr_data = d;
      k       = cyc + 1;
      if (ill && CHK_EN) begin
         err_q.push_back(k);
         if (exp_err_cnt < 255) exp_err_cnt++;
      end
   endtask

   task automatic nop();
      @(negedge clk);
      cmd_val = 1'b0;
      wr_en   = 1'b0;
   endtask

   task automatic act(input int b, input int r, input bit ill);
      int k;
      drive(2'b00, 1'b0, b, r, 0, 16'h0, ill, k);
   endtask

   task automatic wr(input int b, input int col, input logic [15:0] d, input bit ill);
      int k;
      drive(2'b01, 1'b1, b, 0, col, d, ill, k);
   endtask

   task automatic rd(input int b, input int col, input logic [15:0] exp, input bit ill);
      int k;
      drive(2'b01, 1'b0, b, 0, col, 16'h0, ill, k);
      if (!ill) rd_q.push_back('{data: exp, cyc: k + CL});
   endtask

   task automatic pre(input int b, input bit ill);
      int k;
      drive(2'b11, 1'b0, b, 0, 0, 16'h0, ill, k);
   endtask

   task automatic refresh(input bit ill);
      int k;
      drive(2'b10, 1'b0, 0, 0, 0, 16'h0, ill, k);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_rdy"},   32'(cmd_rdy),   32'd1);
      check({tag, "_rd_valid"},  32'(rd_valid),  32'd0);
      check({tag, "_rd_data"},   32'(rd_data),   32'd0);
      check({tag, "_bank_open"}, 32'(bank_open), 32'd0);
      check({tag, "_err"},       32'(err),       32'd0);
      check({tag, "_err_count"}, 32'(err_count), 32'd0);
   endtask

   // ------------------------------------------------------------- monitor
   always @(negedge clk) begin : mon
      rd_exp_t e;
      int      ec;
      while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
         e = rd_q.pop_front();
         check("rd_missing", 32'(cyc), 32'(e.cyc));
      end
      if (rd_valid) begin
         if (rd_q.size() == 0) begin
            check("rd_unexpected", 32'(rd_valid), 32'd0);
         end else begin
            e = rd_q.pop_front();
            check("rd_cycle", 32'(cyc), 32'(e.cyc));
            check("rd_data", 32'(rd_data), 32'(e.data));
         end
      end
      while (err_q.size() > 0 && err_q[0] < cyc) begin
         ec = err_q.pop_front();
         check("err_missing", 32'(cyc), 32'(ec));
      end
      if (err) begin
         if (err_q.size() == 0) begin
            check("err_unexpected", 32'(err), 32'd0);
         end else begin
            ec = err_q.pop_front();
            check("err_cycle", 32'(cyc), 32'(ec));
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      rst_b   = 1'b1;
      cmd_val = 1'b0;
      cmd     = 2'b00;
      wr_en   = 1'b0;
      bank_id = '0;
      row_id  = '0;
      col_id  = '0;
      wr_data = '0;
      #3 rst_b = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_b = 1'b1;

      // Open b3 row 5, write then read back on the following edge.
      act(3, 5, 0);
      nop();
      check("b3_opening_1", 32'(bank_open), 32'h00);
      wr(3, 2, 16'hBEEF, 0);
      check("b3_opening_2", 32'(bank_open), 32'h00);
      rd(3, 2, 16'hBEEF, 0);
      check("b3_open", 32'(bank_open), 32'h08);
      wr(3, 5, 16'h1111, 0);
      rd(3, 5, 16'h1111, 0);
      act(3, 6, 1);                 // ACTIVATE on an open bank
      rd(3, 2, 16'hBEEF, 0);

      // ACCESS during ACTIVATING is illegal; legal again at k+T_RCD.
      act(1, 9, 0);
      rd(1, 4, 16'h0, 1);
      wr(1, 4, 16'h1234, 0);
      rd(1, 4, 16'h1234, 0);
      nop();
      check("err_count_a", 32'(err_count), 32'(exp_err_cnt));

      // PRECHARGE b0, early ACTIVATE illegal, ACTIVATE at k+T_RP legal.
      act(0, 7, 0);
      nop();
      nop();
      pre(0, 0);
      check("b0_open", 32'(bank_open), 32'h0B);
      act(0, 7, 1);
      check("b0_closed", 32'(bank_open), 32'h0A);
      act(0, 7, 0);
      check("b0_pre_1", 32'(bank_open), 32'h0A);
      nop();
      check("b0_react_1", 32'(bank_open), 32'h0A);
      nop();
      check("b0_react_2", 32'(bank_open), 32'h0A);
      nop();
      check("b0_reopen", 32'(bank_open), 32'h0B);

      // PRECHARGE during ACTIVATING is illegal; PRECHARGE on idle is a no-op.
      act(5, 1, 0);
      pre(5, 1);
      wr(0, 7, 16'h00C7, 0);
      rd(0, 7, 16'h00C7, 0);
      rd(3, 2, 16'hBEEF, 0);
      pre(4, 0);
      pre(0, 0);
      pre(1, 0);
      pre(3, 0);
      pre(5, 0);

      // REFRESH with b2 open is illegal and leaves cmd_rdy high.
      act(2, 3, 0);
      nop();
      nop();
      refresh(1);
      nop();
      check("ref_blocked_rdy", 32'(cmd_rdy), 32'd1);
      check("err_count_b", 32'(err_count), 32'(exp_err_cnt));
      pre(2, 0);
      nop();
      nop();

      // Legal REFRESH: cmd_rdy low after edges k..k+T_RFC-1.
      refresh(0);
      for (int i = 0; i < 8; i++) begin
         nop();
         check($sformatf("ref_busy_%0d", i), 32'(cmd_rdy), 32'd0);
      end
      check("ref_banks_closed", 32'(bank_open), 32'h00);
      act(6, 2, 0);
      check("ref_done_rdy", 32'(cmd_rdy), 32'd1);
      nop();

      // Back-to-back writes then reads on b6.
      wr(6, 0, 16'hA000, 0);
      wr(6, 1, 16'hA001, 0);
      check("b6_open", 32'(bank_open), 32'h40);
      wr(6, 2, 16'hA002, 0);
      wr(6, 3, 16'hA003, 0);
      rd(6, 0, 16'hA000, 0);
      rd(6, 1, 16'hA001, 0);
      rd(6, 2, 16'hA002, 0);
      rd(6, 3, 16'hA003, 0);

      // Reset with reads in flight: they are dropped.
      rd(6, 1, 16'hA001, 0);
      rd(6, 2, 16'hA002, 0);
      @(negedge clk);
      #2;
      cmd_val = 1'b0;
      rst_b   = 1'b0;
      #1;
      check_reset_outputs("midrst");
      rd_q.delete();
      err_q.delete();
      exp_err_cnt = 0;
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      nop();
      check("post_rst_open", 32'(bank_open), 32'h00);
      check("post_rst_rdy", 32'(cmd_rdy), 32'd1);

      // 300 illegal accesses to an idle bank saturate the counter.
      for (int i = 0; i < 300; i++) begin
         rd(6, 0, 16'h0, 1);
      end
      nop();
      nop();
      check("err_count_sat", 32'(err_count), 32'(exp_err_cnt));
      check("err_count_sat_lim", 32'(err_count), CHK_EN ? 32'd255 : 32'd0);

      repeat (4) nop();
      check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      check("err_queue_empty", 32'(err_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
